// File: rtl/keypad_scan_if.sv
// rtl/keypad_scan_if.sv - keypad header and CPU read-side signals of the keypad scanner
interface keypad_scan_if;
   logic [3:0] col;
   logic [3:0] row;
   logic       rd;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;
   logic       overrun;

   modport slave (
      output col, key_code, key_valid, key_down, overrun,
      input  row, rd
   );

   modport master (
      input  col, key_code, key_valid, key_down, overrun,
      output row, rd
   );
endinterface

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with frame debounce and latched key event
module keypad_scan #(
   parameter int SCAN_DIV = 62500,
   parameter int DEBOUNCE = 5
) (
   input  logic         clk,
   input  logic         reset_,
   keypad_scan_if.slave kif
);
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] dwell;
   logic [1:0]    col_idx;
   logic [3:0]    col_q;
   logic [3:0]    sync1, sync2;
   logic [3:0]    pressed;
   logic [15:0]   snapshot, previous, debounced, frame;
   logic [3:0]    stable;
   logic          tick, frame_end, accept, single;
   logic          evt_pend;
   logic [3:0]    evt_code;
   logic [3:0]    key_code_q;
   logic          key_valid_q, key_down_q, overrun_q;

   function automatic logic [3:0] bit_index(input logic [15:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   assign pressed   = ~sync2;
   assign tick      = (dwell == CW'(SCAN_DIV - 1));
   assign frame_end = tick && (col_idx == 2'd3);

   // The frame under evaluation must include the column being sampled this tick.
   always_comb begin
      frame = snapshot;
      frame[{col_idx, 2'b00} +: 4] = pressed;
   end

   assign accept = frame_end && (frame == previous) && (stable == 4'(DEBOUNCE - 1));
   assign single = (frame != 16'h0000) && ((frame & (frame - 16'd1)) == 16'h0000);

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         dwell    <= '0;
         col_idx  <= 2'd0;
         col_q    <= 4'b1110;
         sync1    <= 4'b1111;
         sync2    <= 4'b1111;
         snapshot <= 16'h0000;
      end else begin
         sync1 <= kif.row;
         sync2 <= sync1;
         if (tick) begin
            dwell    <= '0;
            snapshot <= frame;
            col_idx  <= col_idx + 2'd1;
            col_q    <= {col_q[2:0], col_q[3]};
         end else begin
            dwell <= dwell + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         previous   <= 16'h0000;
         debounced  <= 16'h0000;
         stable     <= 4'd0;
         key_down_q <= 1'b0;
         evt_pend   <= 1'b0;
         evt_code   <= 4'd0;
      end else begin
         evt_pend <= 1'b0;
         if (frame_end) begin
            previous <= frame;
            if (frame != previous) begin
               stable <= 4'd0;
            end else if (stable != 4'(DEBOUNCE)) begin
               stable <= stable + 4'd1;
            end
            if (accept) begin
               debounced  <= frame;
               key_down_q <= |frame;
               // Only a press from all-released to exactly one key is an event.
               evt_pend   <= (debounced == 16'h0000) && single;
               evt_code   <= bit_index(frame);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else if (evt_pend) begin
         key_code_q  <= evt_code;
         key_valid_q <= 1'b1;
         if (kif.rd) begin
            overrun_q <= 1'b0;
         end else if (key_valid_q) begin
            overrun_q <= 1'b1;
         end
      end else if (kif.rd) begin
         key_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end
   end

   assign kif.col       = col_q;
   assign kif.key_code  = key_code_q;
   assign kif.key_valid = key_valid_q;
   assign kif.key_down  = key_down_q;
   assign kif.overrun   = overrun_q;
endmodule
